// File: rtl/prog_run_ctrl_if.sv
// Handshake and status bundle between the run controller and the bench/core.
// The slave modport is the controller's view; the master modport is the requester's view.
interface prog_run_ctrl_if #(
    parameter int A = 12
);
    logic          req;
    logic          halt;
    logic          ack;
    logic          core_init;
    logic          run_en;
    logic [A-1:0]  start_pc;
    logic [1:0]    prog_idx;
    logic [15:0]   cycle_count;
    logic          timeout;

    modport slave (
        input  req,
        input  halt,
        output ack,
        output core_init,
        output run_en,
        output start_pc,
        output prog_idx,
        output cycle_count,
        output timeout
    );

    modport master (
        output req,
        output halt,
        input  ack,
        input  core_init,
        input  run_en,
        input  start_pc,
        input  prog_idx,
        input  cycle_count,
        input  timeout
    );
endinterface

// File: rtl/prog_run_ctrl.sv
// Sequences NPROG programs on a core: init pulse, run with cycle budget, done/ack.
// Every output is a flop updated together with the state register.
module prog_run_ctrl #(
    parameter int              A           = 12,
    parameter int              NPROG       = 3,
    parameter logic [A-1:0]    START0      = 12'h000,
    parameter logic [A-1:0]    START1      = 12'h100,
    parameter logic [A-1:0]    START2      = 12'h200,
    parameter logic [A-1:0]    START3      = 12'h300,
    parameter int              INIT_CYCLES = 2,
    parameter logic [15:0]     TIMEOUT     = 16'd1000
) (
    input  logic              clk,
    input  logic              reset,
    prog_run_ctrl_if.slave    bus
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [1:0]    IDX_LAST  = 2'(NPROG - 1);
    localparam logic [15:0]   CNT_LAST  = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;
    logic            ack_q, ack_d;
    logic            core_init_q, core_init_d;
    logic            run_en_q, run_en_d;
    logic [A-1:0]    start_pc_q, start_pc_d;
    logic [1:0]      prog_idx_q, prog_idx_d;
    logic [15:0]     cycle_q, cycle_d;
    logic            timeout_q, timeout_d;

    function automatic logic [A-1:0] start_of(input logic [1:0] idx);
        logic [A-1:0] pc;
        case (idx)
            2'd0:    pc = START0;
            2'd1:    pc = START1;
            2'd2:    pc = START2;
            2'd3:    pc = START3;
            default: pc = START0;
        endcase
        return pc;
    endfunction

    // Next program index; wraps at NPROG-1 so NPROG=1 pins the index at 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] n;
        if (idx >= IDX_LAST) begin
            n = 2'd0;
        end else begin
            n = idx + 2'd1;
        end
        return n;
    endfunction

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            init_cnt_q  <= '0;
            ack_q       <= 1'b0;
            core_init_q <= 1'b1;
            run_en_q    <= 1'b0;
            start_pc_q  <= START0;
            prog_idx_q  <= 2'd0;
            cycle_q     <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ack_q       <= ack_d;
            core_init_q <= core_init_d;
            run_en_q    <= run_en_d;
            start_pc_q  <= start_pc_d;
            prog_idx_q  <= prog_idx_d;
            cycle_q     <= cycle_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a branch changes it.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ack_d       = ack_q;
        core_init_d = core_init_q;
        run_en_d    = run_en_q;
        start_pc_d  = start_pc_q;
        prog_idx_d  = prog_idx_q;
        cycle_d     = cycle_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                ack_d       = 1'b0;
                core_init_d = 1'b1;
                run_en_d    = 1'b0;
                if (bus.req) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    start_pc_d = start_of(prog_idx_q);
                    cycle_d    = 16'd0;
                    timeout_d  = 1'b0;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d     = S_RUN;
                    init_cnt_d  = '0;
                    core_init_d = 1'b0;
                    run_en_d    = 1'b1;
                end else begin
                    init_cnt_d  = init_cnt_q + IW'(1);
                    core_init_d = 1'b1;
                    run_en_d    = 1'b0;
                end
            end
            S_RUN: begin
                // halt is checked first so it wins over a coincident budget expiry.
                if (bus.halt) begin
                    state_d     = S_DONE;
                    ack_d       = 1'b1;
                    timeout_d   = 1'b0;
                    run_en_d    = 1'b0;
                    core_init_d = 1'b1;
                end else if (cycle_q >= CNT_LAST) begin
                    state_d     = S_DONE;
                    ack_d       = 1'b1;
                    timeout_d   = 1'b1;
                    cycle_d     = TIMEOUT;
                    run_en_d    = 1'b0;
                    core_init_d = 1'b1;
                end else begin
                    cycle_d     = cycle_q + 16'd1;
                end
            end
            S_DONE: begin
                if (bus.req) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    ack_d      = 1'b0;
                    prog_idx_d = next_idx(prog_idx_q);
                    start_pc_d = start_of(next_idx(prog_idx_q));
                    cycle_d    = 16'd0;
                    timeout_d  = 1'b0;
                end else begin
                    state_d    = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                init_cnt_d  = '0;
                ack_d       = 1'b0;
                core_init_d = 1'b1;
                run_en_d    = 1'b0;
                start_pc_d  = START0;
                prog_idx_d  = 2'd0;
                cycle_d     = 16'd0;
                timeout_d   = 1'b0;
            end
        endcase
    end

    assign bus.ack         = ack_q;
    assign bus.core_init   = core_init_q;
    assign bus.run_en      = run_en_q;
    assign bus.start_pc    = start_pc_q;
    assign bus.prog_idx    = prog_idx_q;
    assign bus.cycle_count = cycle_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: init pulse, halt, timeout, tie-break, wrap, reset mid-run.
module tb_prog_run_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    prog_run_ctrl_if #(.A(12)) bus ();

    prog_run_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic a, input logic ci, input logic re,
                           input logic [11:0] pc, input logic [1:0] idx,
                           input logic [15:0] cc, input logic to);
        chk({tag, ".ack"}, 32'(bus.ack), 32'(a));
        chk({tag, ".core_init"}, 32'(bus.core_init), 32'(ci));
        chk({tag, ".run_en"}, 32'(bus.run_en), 32'(re));
        chk({tag, ".start_pc"}, 32'(bus.start_pc), 32'(pc));
        chk({tag, ".prog_idx"}, 32'(bus.prog_idx), 32'(idx));
        chk({tag, ".cycle_count"}, 32'(bus.cycle_count), 32'(cc));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.req  = 1'b0;
        bus.halt = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_all("reset", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);

        // halt in IDLE does nothing
        bus.halt = 1'b1;
        tick(1);
        bus.halt = 1'b0;
        chk_all("idle_halt", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);

        // program 0: two init cycles, then run; req during INIT is ignored
        bus.req = 1'b1;
        tick(1);
        chk_all("p0_init1", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);
        tick(1);
        bus.req = 1'b0;
        chk_all("p0_init2", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);
        tick(1);
        chk_all("p0_run", 1'b0, 1'b0, 1'b1, 12'h000, 2'd0, 16'd0, 1'b0);
        tick(4);
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        tick(4);
        chk_all("p0_run9", 1'b0, 1'b0, 1'b1, 12'h000, 2'd0, 16'd9, 1'b0);
        bus.halt = 1'b1;
        tick(1);
        chk_all("p0_halt", 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 16'd9, 1'b0);
        tick(1);
        bus.halt = 1'b0;
        chk_all("p0_done_hold", 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 16'd9, 1'b0);

        // program 1: run into the timeout
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        chk_all("p1_init", 1'b0, 1'b1, 1'b0, 12'h100, 2'd1, 16'd0, 1'b0);
        tick(2);
        chk_all("p1_run", 1'b0, 1'b0, 1'b1, 12'h100, 2'd1, 16'd0, 1'b0);
        tick(999);
        chk_all("p1_run999", 1'b0, 1'b0, 1'b1, 12'h100, 2'd1, 16'd999, 1'b0);
        tick(1);
        chk_all("p1_timeout", 1'b1, 1'b1, 1'b0, 12'h100, 2'd1, 16'd1000, 1'b1);
        tick(3);
        chk_all("p1_done_hold", 1'b1, 1'b1, 1'b0, 12'h100, 2'd1, 16'd1000, 1'b1);

        // program 2: halt coincides with the timeout edge, halt wins
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        chk_all("p2_init", 1'b0, 1'b1, 1'b0, 12'h200, 2'd2, 16'd0, 1'b0);
        tick(2);
        tick(999);
        chk_all("p2_run999", 1'b0, 1'b0, 1'b1, 12'h200, 2'd2, 16'd999, 1'b0);
        bus.halt = 1'b1;
        tick(1);
        bus.halt = 1'b0;
        chk_all("p2_halt_wins", 1'b1, 1'b1, 1'b0, 12'h200, 2'd2, 16'd999, 1'b0);

        // wrap back to program 0, halt on the first run edge
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        chk_all("wrap_init", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);
        tick(2);
        bus.halt = 1'b1;
        tick(1);
        bus.halt = 1'b0;
        chk_all("wrap_halt", 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);

        // advance to program 2 and reset it mid-run at cycle 500
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        tick(2);
        bus.halt = 1'b1;
        tick(1);
        bus.halt = 1'b0;
        bus.req  = 1'b1;
        tick(1);
        bus.req  = 1'b0;
        chk_all("p2b_init", 1'b0, 1'b1, 1'b0, 12'h200, 2'd2, 16'd0, 1'b0);
        tick(2);
        tick(250);
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        tick(249);
        chk_all("p2b_run500", 1'b0, 1'b0, 1'b1, 12'h200, 2'd2, 16'd500, 1'b0);
        reset    = 1'b1;
        bus.halt = 1'b1;
        bus.req  = 1'b1;
        tick(1);
        reset    = 1'b0;
        bus.halt = 1'b0;
        bus.req  = 1'b0;
        chk_all("mid_reset", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);
        tick(2);
        chk_all("post_reset_idle", 1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 16'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
